// File: rtl/la_capture_core.sv
// Logic-analyser capture core: synchronised probe bus into a circular
// sample RAM around a masked trigger, then oldest-first readout.
module la_capture_core #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      probe_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      trig_mask,
  input  logic [WIDTH-1:0]      trig_value,
  input  logic [DEPTH_LOG2-1:0] post_count,
  input  logic                  rd_req,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [2:0]            state,
  output logic                  trig_seen
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } st_e;

  st_e st, st_n;

  logic [WIDTH-1:0]      s1, s;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      mask_q, value_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_cnt;
  logic [DEPTH_LOG2-1:0] fill_cnt, post_left;
  logic [DEPTH_LOG2-1:0] pre_q, post_q, pre_in;
  logic                  we, start, hit, rd_fire, match;

  // DEPTH-1-post_count is the bitwise complement in DEPTH_LOG2 bits
  assign pre_in = ~post_count;
  assign match  = ((s ^ value_q) & mask_q) == '0;
  assign state  = st;

  always_comb begin
    st_n    = st;
    we      = 1'b0;
    start   = 1'b0;
    hit     = 1'b0;
    rd_fire = 1'b0;
    if (abort) begin
      st_n = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (arm) begin
            start = 1'b1;
            st_n  = (pre_in == '0) ? WAIT : FILL;
          end
        end
        FILL: begin
          we = 1'b1;
          if (fill_cnt + ONE == pre_q)
            st_n = WAIT;
        end
        WAIT: begin
          we = 1'b1;
          if (match) begin
            hit  = 1'b1;
            st_n = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          we = 1'b1;
          if (post_left == ONE)
            st_n = DONE;
        end
        DONE: begin
          if (arm) begin
            start = 1'b1;
            st_n  = (pre_in == '0) ? WAIT : FILL;
          end else if (rd_last) begin
            st_n = IDLE;
          end else if (rd_req) begin
            rd_fire = 1'b1;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      s1        <= '0;
      s         <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      fill_cnt  <= '0;
      post_left <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      trig_seen <= 1'b0;
    end else begin
      s1       <= probe_in;
      s        <= s1;
      st       <= st_n;
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && (rd_cnt == '1);
      if (we)
        wr_ptr <= wr_ptr + ONE;
      if (start) begin
        pre_q     <= pre_in;
        post_q    <= post_count;
        mask_q    <= trig_mask;
        value_q   <= trig_value;
        fill_cnt  <= '0;
        trig_seen <= 1'b0;
      end
      if (st == FILL && we)
        fill_cnt <= fill_cnt + ONE;
      if (hit) begin
        trig_seen <= 1'b1;
        post_left <= post_q;
      end
      if (st == POST && we)
        post_left <= post_left - ONE;
      // entry is always on a write cycle, so the oldest slot is wr_ptr+1
      if (st_n == DONE && st != DONE) begin
        rd_ptr <= wr_ptr + ONE;
        rd_cnt <= '0;
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ONE;
        rd_cnt  <= rd_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at DEPTH=16: trigger placement,
// readout order, wrap, abort and reset behaviour.
module tb_la_capture_core;

  localparam int W  = 16;
  localparam int DL = 4;
  localparam int D  = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  probe_in;
  logic          arm, abort, rd_req;
  logic [W-1:0]  trig_mask, trig_value;
  logic [DL-1:0] post_count;
  logic [W-1:0]  rd_data;
  logic          rd_valid, rd_last, trig_seen;
  logic [2:0]    state;

  int errs   = 0;
  int checks = 0;
  logic         ctr_on;
  logic [W-1:0] rdw [D];

  la_capture_core #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .probe_in   (probe_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .state      (state),
    .trig_seen  (trig_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ctr_on)
      probe_in = probe_in + 16'd1;
  endtask

  task automatic wait_st(input string tag,
                         input logic [2:0] tgt,
                         input int budget,
                         output logic [7:0] seen);
    int n;
    n = 0;
    seen = '0;
    seen[state] = 1'b1;
    while (state !== tgt && n < budget) begin
      step();
      n++;
      seen[state] = 1'b1;
    end
    chk(tag, {29'd0, state}, {29'd0, tgt});
  endtask

  task automatic start(input logic [W-1:0] m,
                       input logic [W-1:0] v,
                       input logic [DL-1:0] p);
    trig_mask  = m;
    trig_value = v;
    post_count = p;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic read_words(input int n);
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == n - 1)
        rd_req = 1'b0;
      chk("rd_vld", {31'd0, rd_valid}, 32'd1);
      chk("rd_last", {31'd0, rd_last}, {31'd0, i == D - 1});
      rdw[i] = rd_data;
    end
    if (n == D) begin
      step();
      chk("rd_end_st", {29'd0, state}, {29'd0, S_IDLE});
      chk("rd_end_vld", {31'd0, rd_valid}, 32'd0);
    end
  endtask

  task automatic check_words(input string tag,
                             input logic [W-1:0] first,
                             input int n);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = first + W'(i);
      chk(tag, {16'd0, rdw[i]}, {16'd0, e});
    end
  endtask

  initial begin
    logic [7:0]   seen;
    logic [W-1:0] v;

    rst_n = 1'b0;
    probe_in = '0;
    arm = 1'b0;
    abort = 1'b0;
    rd_req = 1'b0;
    trig_mask = '0;
    trig_value = '0;
    post_count = '0;
    ctr_on = 1'b0;
    #12;
    chk("rst_st", {29'd0, state}, 32'd0);
    chk("rst_data", {16'd0, rd_data}, 32'd0);
    chk("rst_vld", {31'd0, rd_valid}, 32'd0);
    chk("rst_last", {31'd0, rd_last}, 32'd0);
    chk("rst_trig", {31'd0, trig_seen}, 32'd0);
    #5 rst_n = 1'b1;
    ctr_on = 1'b1;
    repeat (3) step();

    // 1: counter probe, exact-value trigger, pre=10 post=5
    start(16'hFFFF, 16'h0020, 4'd5);
    chk("t1_fill", {29'd0, state}, {29'd0, S_FILL});
    chk("t1_trig0", {31'd0, trig_seen}, 32'd0);
    wait_st("t1_done", S_DONE, 100, seen);
    chk("t1_seenfill", {31'd0, seen[S_FILL]}, 32'd1);
    chk("t1_trig1", {31'd0, trig_seen}, 32'd1);
    chk("t1_novld", {31'd0, rd_valid}, 32'd0);
    read_words(D);
    chk("t1_w0", {16'd0, rdw[0]}, 32'h0016);
    chk("t1_w10", {16'd0, rdw[10]}, 32'h0020);
    chk("t1_w15", {16'd0, rdw[15]}, 32'h0025);
    check_words("t1_w", 16'h0016, D);

    // 2: post=15, mask=0 -> straight to WAIT, trigger on first sample
    v = probe_in - 16'd1;
    start(16'h0000, 16'h0000, 4'd15);
    chk("t2_wait", {29'd0, state}, {29'd0, S_WAIT});
    wait_st("t2_done", S_DONE, 40, seen);
    chk("t2_nofill", {31'd0, seen[S_FILL]}, 32'd0);
    read_words(D);
    check_words("t2_w", v, D);

    // 3: post=0, bit0 rises late -> WAIT straight to DONE
    ctr_on = 1'b0;
    probe_in = 16'h0A00;
    start(16'h0001, 16'h0001, 4'd0);
    repeat (19) step();
    probe_in = 16'h0A01;
    wait_st("t3_done", S_DONE, 40, seen);
    chk("t3_nopost", {31'd0, seen[S_POST]}, 32'd0);
    read_words(D);
    chk("t3_w15", {16'd0, rdw[15]}, 32'h0A01);
    chk("t3_w14", {16'd0, rdw[14]}, 32'h0A00);
    chk("t3_w0", {16'd0, rdw[0]}, 32'h0A00);

    // 6: low-byte match present during FILL is ignored
    ctr_on = 1'b1;
    v = probe_in + 16'd3;
    start(16'h00FF, v & 16'h00FF, 4'd5);
    wait_st("t6_done", S_DONE, 400, seen);
    read_words(D);
    check_words("t6_w", v + 16'd256 - 16'd10, D);

    // 4: back-to-back captures, ptr keeps wrapping
    v = probe_in + 16'd40;
    start(16'hFFFF, v, 4'd3);
    wait_st("t4a_done", S_DONE, 100, seen);
    read_words(D);
    check_words("t4a_w", v - 16'd12, D);
    v = probe_in + 16'd40;
    start(16'hFFFF, v, 4'd12);
    wait_st("t4b_done", S_DONE, 100, seen);
    read_words(4);
    check_words("t4b_w", v - 16'd3, 4);
    v = probe_in + 16'd40;
    rd_req = 1'b1;
    start(16'hFFFF, v, 4'd0);
    rd_req = 1'b0;
    chk("t4_rearm_vld", {31'd0, rd_valid}, 32'd0);
    chk("t4_rearm_st", {29'd0, state}, {29'd0, S_FILL});
    wait_st("t4c_done", S_DONE, 100, seen);
    read_words(D);
    check_words("t4c_w", v - 16'd15, D);

    // 5: aborts
    start(16'hFFFF, 16'hFFFF, 4'd5);
    wait_st("t5_wait", S_WAIT, 30, seen);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_ab_st", {29'd0, state}, 32'd0);
    chk("t5_ab_vld", {31'd0, rd_valid}, 32'd0);
    v = probe_in + 16'd40;
    start(16'hFFFF, v, 4'd5);
    wait_st("t5_done", S_DONE, 100, seen);
    read_words(5);
    check_words("t5_w", v - 16'd10, 5);
    rd_req = 1'b1;
    abort = 1'b1;
    step();
    rd_req = 1'b0;
    abort = 1'b0;
    chk("t5_rd_st", {29'd0, state}, 32'd0);
    chk("t5_rd_vld", {31'd0, rd_valid}, 32'd0);
    chk("t5_rd_last", {31'd0, rd_last}, 32'd0);
    chk("t5_trig_kept", {31'd0, trig_seen}, 32'd1);
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    chk("t5_both_st", {29'd0, state}, 32'd0);
    chk("t5_both_trig", {31'd0, trig_seen}, 32'd1);

    // async reset while holding a finished capture
    v = probe_in + 16'd40;
    start(16'hFFFF, v, 4'd5);
    wait_st("t7_done", S_DONE, 100, seen);
    read_words(1);
    check_words("t7_w", v - 16'd10, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t7_rst_st", {29'd0, state}, 32'd0);
    chk("t7_rst_trig", {31'd0, trig_seen}, 32'd0);
    chk("t7_rst_data", {16'd0, rd_data}, 32'd0);
    chk("t7_rst_vld", {31'd0, rd_valid}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("t7_post_st", {29'd0, state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
